pakout_serializer: RTL and testbench

PAKOUT_SERIALIZER -- requirements
Module: pakout_serializer

---
 rtl/pakout_serializer.sv | 148 ++++++++++++++
 tb/tb_pakout_serializer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pakout_serializer.sv
// Message-to-packet serializer: 4-phase handshake in, redundancy check, small
// message FIFO, then one 4-phase handshake per packet out, MSB packet first.
module pakout_serializer #(
   parameter int ASZ = 6,
   parameter int DSZ = 4,
   parameter int RSZ = 4,
   parameter int PSZ = 4,
   parameter int FSZ = 2
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic [ASZ-1:0] i0_src,
   input  logic [ASZ-1:0] i0_dst,
   input  logic [DSZ-1:0] i0_dat,
   input  logic [RSZ-1:0] i0_red,
   input  logic           i0_req,
   output logic           i0_ack,
   output logic [PSZ-1:0] o0_pck,
   output logic           o0_req,
   input  logic           o0_ack,
   output logic           err_red,
   output logic [7:0]     msg_cnt
);

   localparam int HSZ     = 2*ASZ + DSZ;
   localparam int MSZ     = HSZ + RSZ;
   localparam int TOT_PKS = (MSZ + PSZ - 1) / PSZ;
   localparam int FLAT    = TOT_PKS * PSZ;
   localparam int PAD     = FLAT - MSZ;
   localparam int PW      = $clog2(FSZ);
   localparam int CW      = PW + 1;
   localparam int IW      = (TOT_PKS > 1) ? $clog2(TOT_PKS) : 1;

   typedef enum logic [1:0] {IDLE, LOAD, SEND, DROP} state_t;

   // XOR-fold of the protected fields into RSZ-bit chunks, LSB-aligned.
   function automatic logic [RSZ-1:0] calc_redun(input logic [HSZ-1:0] v);
      logic [RSZ-1:0] r;
      r = '0;
      for (int k = 0; k < (HSZ + RSZ - 1) / RSZ; k++) r = r ^ RSZ'(v >> (k*RSZ));
      return r;
   endfunction

   logic           req_s1_q, req_s2_q, ack_s1_q, ack_s2_q;
   logic           i0_ack_q, err_red_q;
   logic [MSZ-1:0] fifo_mem_q [FSZ];
   logic [PW-1:0]  head_q, tail_q;
   logic [CW-1:0]  count_q;
   state_t         state_q, state_d;
   logic [IW-1:0]  pk_idx_q, pk_idx_d;
   logic [FLAT-1:0] shift_q, shift_d;
   logic [7:0]     msg_cnt_q, msg_cnt_d;

   logic full, empty, capture, red_ok, push, pop;

   assign full    = (count_q == CW'(FSZ));
   assign empty   = (count_q == '0);
   assign capture = req_s2_q & ~i0_ack_q & ~full;
   assign red_ok  = (i0_red == calc_redun({i0_src, i0_dst, i0_dat}));
   assign push    = capture & red_ok;
   assign pop     = (state_q == LOAD);

   // NOTE: sequential state uses <= so every flop samples pre-edge values;
   // blocking here would let later statements see already-updated registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         req_s1_q  <= 1'b0;
         req_s2_q  <= 1'b0;
         ack_s1_q  <= 1'b0;
         ack_s2_q  <= 1'b0;
         i0_ack_q  <= 1'b0;
         err_red_q <= 1'b0;
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
      end else begin
         req_s1_q <= i0_req;
         req_s2_q <= req_s1_q;
         ack_s1_q <= o0_ack;
         ack_s2_q <= ack_s1_q;
         if (capture)                    i0_ack_q <= 1'b1;
         else if (i0_ack_q && !req_s2_q) i0_ack_q <= 1'b0;
         if (capture && !red_ok) err_red_q <= 1'b1;
         if (push) tail_q <= tail_q + 1'b1;
         if (pop)  head_q <= head_q + 1'b1;
         if (push && !pop)      count_q <= count_q + 1'b1;
         else if (pop && !push) count_q <= count_q - 1'b1;
      end
   end

   // NOTE: the storage array is deliberately not reset; the count alone
   // decides validity, so stale words are never read.
   always_ff @(posedge clk) begin
      if (push) fifo_mem_q[tail_q] <= {i0_src, i0_dst, i0_dat, i0_red};
   end

   // NOTE: every variable gets a default before the case, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      pk_idx_d  = pk_idx_q;
      shift_d   = shift_q;
      msg_cnt_d = msg_cnt_q;
      case (state_q)
         IDLE: if (!empty) state_d = LOAD;
         LOAD: begin
            shift_d  = FLAT'(fifo_mem_q[head_q]) << PAD;
            pk_idx_d = '0;
            state_d  = SEND;
         end
         SEND: if (ack_s2_q) state_d = DROP;
         DROP: begin
            if (!ack_s2_q) begin
               if (pk_idx_q == IW'(TOT_PKS - 1)) begin
                  msg_cnt_d = msg_cnt_q + 8'd1;
                  state_d   = IDLE;
               end else begin
                  pk_idx_d = pk_idx_q + 1'b1;
                  shift_d  = shift_q << PSZ;
                  state_d  = SEND;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         pk_idx_q  <= '0;
         shift_q   <= '0;
         msg_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         pk_idx_q  <= pk_idx_d;
         shift_q   <= shift_d;
         msg_cnt_q <= msg_cnt_d;
      end
   end

   assign i0_ack  = i0_ack_q;
   assign err_red = err_red_q;
   assign msg_cnt = msg_cnt_q;
   assign o0_req  = (state_q == SEND);
   assign o0_pck  = shift_q[FLAT-1 -: PSZ];

endmodule

// File: tb/tb_pakout_serializer.sv
// Self-checking bench for pakout_serializer: random messages and ack delays,
// checked against a packet-queue model derived from the message fields.
module tb_pakout_serializer;

   localparam int ASZ = 6, DSZ = 4, RSZ = 4, PSZ = 4;
   localparam int HSZ = 2*ASZ + DSZ;
   localparam int MSZ = HSZ + RSZ;
   localparam int TOT = (MSZ + PSZ - 1) / PSZ;
   localparam int PAD = TOT*PSZ - MSZ;

   logic           clk = 1'b0;
   logic           reset_n = 1'b0;
   logic [ASZ-1:0] i0_src = '0, i0_dst = '0;
   logic [DSZ-1:0] i0_dat = '0;
   logic [RSZ-1:0] i0_red = '0;
   logic           i0_req = 1'b0, i0_ack;
   logic [PSZ-1:0] o0_pck;
   logic           o0_req, o0_ack, err_red;
   logic [7:0]     msg_cnt;

   int n_checks = 0, n_fail = 0;
   int exp_q[$], seen_q[$];
   int model_msgs = 0;
   bit resp_en = 1'b0, resp_busy;
   int dmin = 0, dmax = 0;

   pakout_serializer dut (
      .clk(clk), .reset_n(reset_n),
      .i0_src(i0_src), .i0_dst(i0_dst), .i0_dat(i0_dat), .i0_red(i0_red),
      .i0_req(i0_req), .i0_ack(i0_ack),
      .o0_pck(o0_pck), .o0_req(o0_req), .o0_ack(o0_ack),
      .err_red(err_red), .msg_cnt(msg_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Redundancy: bit i of the protected word toggles redundancy bit i mod RSZ.
   function automatic int model_red(input int src, input int dst, input int dat);
      longint v;
      int r;
      v = (longint'(src) << (ASZ + DSZ)) | (longint'(dst) << DSZ) | longint'(dat);
      r = 0;
      for (int i = 0; i < HSZ; i++) if (((v >> i) & 1) != 0) r = r ^ (1 << (i % RSZ));
      return r;
   endfunction

   function automatic void model_push(input int src, input int dst, input int dat, input int red);
      longint flat;
      flat = (((longint'(src) << (ASZ + DSZ)) | (longint'(dst) << DSZ) | longint'(dat)) << RSZ) | longint'(red);
      flat = flat << PAD;
      for (int k = 0; k < TOT; k++) exp_q.push_back(int'((flat >> (PSZ*(TOT-1-k))) & ((1 << PSZ) - 1)));
      model_msgs++;
   endfunction

   // Packet responder and compare process.
   initial begin
      logic [PSZ-1:0] cap;
      int  dly;
      bit  live, done;
      o0_ack = 1'b0;
      resp_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (resp_en && o0_req) begin
            resp_busy = 1'b1;
            seen_q.push_back(int'(o0_pck));
            check("pkt_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check("pkt_data", o0_pck, exp_q.pop_front());
            cap  = o0_pck;
            dly  = $urandom_range(dmax, dmin);
            live = 1'b1;
            for (int i = 0; i < dly && live; i++) begin
               @(negedge clk);
               live = resp_en;
               if (live && o0_req) check("pck_stable", o0_pck, cap);
            end
            if (live) begin
               o0_ack = 1'b1;
               done = 1'b0;
               for (int i = 0; i < 100 && live && !done; i++) begin
                  @(negedge clk);
                  live = resp_en;
                  if (!o0_req) done = 1'b1;
                  else if (live) check("pck_stable", o0_pck, cap);
               end
               if (live) check("req_drop", done, 1);
            end
            o0_ack = 1'b0;
            resp_busy = 1'b0;
         end else begin
            o0_ack = 1'b0;
         end
      end
   end

   task automatic start_req(input int src, input int dst, input int dat, input int red);
      @(negedge clk);
      i0_src = ASZ'(src); i0_dst = ASZ'(dst); i0_dat = DSZ'(dat); i0_red = RSZ'(red);
      i0_req = 1'b1;
   endtask

   task automatic wait_ack(input int limit, output bit got);
      got = 1'b0;
      for (int i = 0; i < limit && !got; i++) begin
         @(negedge clk);
         if (i0_ack) got = 1'b1;
      end
   endtask

   task automatic finish_req();
      bit low;
      i0_req = 1'b0;
      low = 1'b0;
      for (int i = 0; i < 20 && !low; i++) begin
         @(negedge clk);
         if (!i0_ack) low = 1'b1;
      end
      check("i0_ack_release", low, 1);
   endtask

   task automatic send_msg(input int src, input int dst, input int dat, input int red);
      bit got;
      start_req(src, dst, dat, red);
      wait_ack(3000, got);
      check("i0_ack_seen", got, 1);
      if (got && red == model_red(src, dst, dat)) model_push(src, dst, dat, red);
      finish_req();
   endtask

   task automatic send_rand();
      int s, d, t;
      s = $urandom_range(63, 0); d = $urandom_range(63, 0); t = $urandom_range(15, 0);
      send_msg(s, d, t, model_red(s, d, t));
   endtask

   task automatic drain();
      int i;
      for (i = 0; i < 6000; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !resp_busy && !o0_req) break;
      end
      check("drain_done", i < 6000, 1);
      repeat (10) @(negedge clk);
   endtask

   task automatic apply_reset(input int cycles);
      @(negedge clk);
      resp_en = 1'b0;
      i0_req = 1'b0;
      reset_n = 1'b0;
      repeat (cycles) @(negedge clk);
      exp_q.delete();
      model_msgs = 0;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int  base;
      bit  got, ack_seen;
      int  lit [5];
      lit = '{0, 12, 1, 5, 8};

      // Reset values.
      apply_reset(3);
      check("rst_i0_ack", i0_ack, 0);
      check("rst_o0_req", o0_req, 0);
      check("rst_o0_pck", o0_pck, 0);
      check("rst_err_red", err_red, 0);
      check("rst_msg_cnt", msg_cnt, 0);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      resp_en = 1'b1;

      // Single known message; redundancy and packets pinned by hand.
      check("model_red_pin", model_red(3, 1, 5), 8);
      dmin = 0; dmax = 4;
      base = seen_q.size();
      send_msg(3, 1, 5, model_red(3, 1, 5));
      drain();
      check("single_npk", seen_q.size() - base, 5);
      for (int k = 0; k < 5; k++) check("single_pk_lit", seen_q[base + k], lit[k]);
      check("single_msg_cnt", msg_cnt, 1);
      check("single_err_red", err_red, 0);

      // Bad redundancy: acked, dropped, sticky error.
      base = seen_q.size();
      send_msg(10, 20, 7, model_red(10, 20, 7) ^ 1);
      repeat (30) @(negedge clk);
      check("bad_no_pkt", seen_q.size() - base, 0);
      check("bad_err_red", err_red, 1);
      send_rand();
      drain();
      check("bad_err_sticky", err_red, 1);
      check("bad_msg_cnt", msg_cnt, 8'(model_msgs));

      // Back-pressure: first loaded, two queued, fourth waits for space.
      resp_en = 1'b0;
      send_rand();
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (o0_req) got = 1'b1;
      end
      check("bp_first_loaded", got, 1);
      send_rand();
      send_rand();
      begin
         int s, d, t;
         s = $urandom_range(63, 0); d = $urandom_range(63, 0); t = $urandom_range(15, 0);
         start_req(s, d, t, model_red(s, d, t));
         ack_seen = 1'b0;
         repeat (40) begin
            @(negedge clk);
            if (i0_ack) ack_seen = 1'b1;
         end
         check("bp_full_no_ack", ack_seen, 0);
         resp_en = 1'b1;
         wait_ack(3000, got);
         check("bp_ack_after_drain", got, 1);
         if (got) model_push(s, d, t, model_red(s, d, t));
         finish_req();
      end
      drain();
      check("bp_msg_cnt", msg_cnt, 8'(model_msgs));

      // Long random run from a fresh reset with a stalling responder.
      apply_reset(1);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      resp_en = 1'b1;
      dmin = 0; dmax = 20;
      repeat (300) send_rand();
      drain();
      check("rand_msg_cnt_model", msg_cnt, 8'(model_msgs));
      check("rand_msg_cnt_lit", msg_cnt, 44);
      check("rand_err_red", err_red, 0);

      // Reset during packet 2 abandons the message.
      dmin = 6; dmax = 6;
      base = seen_q.size();
      send_msg(63, 0, 9, model_red(63, 0, 9));
      got = 1'b0;
      for (int i = 0; i < 500 && !got; i++) begin
         @(negedge clk);
         if (seen_q.size() >= base + 3) got = 1'b1;
      end
      check("rst_mid_reached_pk2", got, 1);
      resp_en = 1'b0;
      reset_n = 1'b0;
      @(negedge clk);
      check("rst_mid_o0_req", o0_req, 0);
      check("rst_mid_msg_cnt", msg_cnt, 0);
      reset_n = 1'b1;
      exp_q.delete();
      model_msgs = 0;
      repeat (15) @(negedge clk);
      check("rst_mid_no_resend", seen_q.size() - base, 3);
      check("rst_mid_o0_req_idle", o0_req, 0);
      resp_en = 1'b1;
      dmin = 0; dmax = 3;
      base = seen_q.size();
      send_msg(3, 1, 5, model_red(3, 1, 5));
      drain();
      check("rst_restart_pk0", seen_q[base], 0);
      check("rst_restart_pk1", seen_q[base + 1], 12);
      check("rst_restart_msg_cnt", msg_cnt, 1);

      // Varying gaps so request release overlaps FIFO pops at many phases.
      dmin = 0; dmax = 2;
      for (int g = 0; g < 16; g++) begin
         send_rand();
         repeat (g) @(negedge clk);
      end
      drain();
      check("gap_msg_cnt", msg_cnt, 8'(model_msgs));
      check("gap_queue_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
